// File: rtl/burst_gate_ctrl.sv
// Burst gate sequencer: runs optional pre-guard, channel-on and post-guard phases
// after a start request, with abort and asynchronous reset; every output is registered.
module burst_gate_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] pre_guard,
    input  logic [CNT_W-1:0] burst_len,
    input  logic [CNT_W-1:0] post_guard,
    output logic             mode,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] sample_idx
);

    typedef enum logic [1:0] {IDLE, PRE, ON, POST} state_t;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] pre_q, len_q, post_q;
    logic [CNT_W-1:0] cur_len;
    logic             load, fin_evt, abort_evt;
    logic             mode_nxt, busy_nxt, done_nxt, aborted_nxt;
    logic [CNT_W-1:0] idx_nxt;

    // First phase after 'cur' whose length is nonzero; IDLE as 'cur' means "from the top".
    function automatic state_t next_phase(input state_t cur,
                                          input logic [CNT_W-1:0] p,
                                          input logic [CNT_W-1:0] l,
                                          input logic [CNT_W-1:0] q);
        state_t s;
        s = IDLE;
        case (cur)
            IDLE: begin
                if (p != '0)      s = PRE;
                else if (l != '0) s = ON;
                else if (q != '0) s = POST;
            end
            PRE: begin
                if (l != '0)      s = ON;
                else if (q != '0) s = POST;
            end
            ON: begin
                if (q != '0)      s = POST;
            end
            default: s = IDLE;
        endcase
        return s;
    endfunction

    always_comb begin
        case (state)
            PRE:     cur_len = pre_q;
            ON:      cur_len = len_q;
            POST:    cur_len = post_q;
            default: cur_len = '0;
        endcase
    end

    // State register and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            mode       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            sample_idx <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            mode       <= mode_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            aborted    <= aborted_nxt;
            sample_idx <= idx_nxt;
        end
    end

    // Operands are plain data: captured only on the accepting edge.
    always_ff @(posedge clk) begin
        if (load) begin
            pre_q  <= pre_guard;
            len_q  <= burst_len;
            post_q <= post_guard;
        end
    end

    // Next-state logic; cnt counts up within a phase so it never exceeds length-1.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        fin_evt   = 1'b0;
        abort_evt = 1'b0;
        if (state == IDLE) begin
            if (start && !abort) begin
                load      = 1'b1;
                cnt_nxt   = '0;
                state_nxt = next_phase(IDLE, pre_guard, burst_len, post_guard);
                fin_evt   = (state_nxt == IDLE);
            end
        end else if (abort) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            abort_evt = 1'b1;
        end else if (cnt == cur_len - ONE) begin
            state_nxt = next_phase(state, pre_q, len_q, post_q);
            cnt_nxt   = '0;
            fin_evt   = (state_nxt == IDLE);
        end else begin
            cnt_nxt = cnt + ONE;
        end
    end

    // Output logic: values the output registers take on the coming edge.
    always_comb begin
        mode_nxt    = (state_nxt == ON);
        busy_nxt    = (state_nxt != IDLE);
        done_nxt    = fin_evt;
        aborted_nxt = abort_evt;
        idx_nxt     = (state_nxt == ON) ? cnt_nxt : '0;
    end

endmodule

// File: tb/tb_burst_gate_ctrl.sv
// Scoreboard bench for burst_gate_ctrl: the driver queues per-cycle expected outputs,
// the monitor pops and compares them against a 16-bit and a 4-bit counter instance.
module tb_burst_gate_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] pre_guard = '0, burst_len = '0, post_guard = '0;
    logic        mode, busy, done, aborted;
    logic [15:0] sample_idx;
    logic        mode4, busy4, done4, aborted4;
    logic [3:0]  sample_idx4;

    always #5 clk = ~clk;

    burst_gate_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .pre_guard(pre_guard), .burst_len(burst_len), .post_guard(post_guard),
        .mode(mode), .busy(busy), .done(done), .aborted(aborted),
        .sample_idx(sample_idx)
    );

    burst_gate_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .pre_guard(pre_guard[3:0]), .burst_len(burst_len[3:0]), .post_guard(post_guard[3:0]),
        .mode(mode4), .busy(busy4), .done(done4), .aborted(aborted4),
        .sample_idx(sample_idx4)
    );

    typedef struct {
        string       name;
        logic [19:0] v;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    function automatic logic [19:0] pack(input logic m, input logic b, input logic d,
                                         input logic a, input logic [15:0] i);
        return {m, b, d, a, i};
    endfunction

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got {mode,busy,done,aborted,idx}=%0b%0b%0b%0b/%0d want %0b%0b%0b%0b/%0d",
                     name, act[19], act[18], act[17], act[16], act[15:0],
                     want[19], want[18], want[17], want[16], want[15:0]);
        end
    endtask

    function automatic logic [19:0] act16();
        return pack(mode, busy, done, aborted, sample_idx);
    endfunction

    function automatic logic [19:0] act4();
        return pack(mode4, busy4, done4, aborted4, {12'b0, sample_idx4});
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check({mon_e.name, "/w16"}, act16(), mon_e.v);
            check({mon_e.name, "/w4"}, act4(), {mon_e.v[19:16], 12'b0, mon_e.v[3:0]});
        end
    end

    task automatic ops(input int p, input int l, input int q);
        pre_guard  = 16'(p);
        burst_len  = 16'(l);
        post_guard = 16'(q);
    endtask

    // Drive start/abort for one edge, then queue the outputs expected after that edge.
    task automatic cyc(input string name, input logic st, input logic ab,
                       input logic m, input logic b, input logic d, input logic a, input int idx);
        exp_t e;
        start = st;
        abort = ab;
        @(posedge clk);
        e.name = name;
        e.v    = pack(m, b, d, a, 16'(idx));
        sb.push_back(e);
        #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        int waited;
        #12;
        check("reset_hold/w16", act16(), '0);
        check("reset_hold/w4", act4(), '0);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // pre=2 len=3 post=1
        ops(2, 3, 1);
        cyc("t1_pre1", 1, 0, 0, 1, 0, 0, 0);
        cyc("t1_pre2", 0, 0, 0, 1, 0, 0, 0);
        cyc("t1_on0",  0, 0, 1, 1, 0, 0, 0);
        cyc("t1_on1",  0, 0, 1, 1, 0, 0, 1);
        cyc("t1_on2",  0, 0, 1, 1, 0, 0, 2);
        cyc("t1_post", 0, 0, 0, 1, 0, 0, 0);
        cyc("t1_done", 0, 0, 0, 0, 1, 0, 0);
        cyc("t1_idle", 0, 0, 0, 0, 0, 0, 0);

        // only an ON phase, then all-zero lengths
        ops(0, 4, 0);
        cyc("t2_on0",  1, 0, 1, 1, 0, 0, 0);
        for (int i = 1; i < 4; i++) cyc("t2_on", 0, 0, 1, 1, 0, 0, i);
        cyc("t2_done", 0, 0, 0, 0, 1, 0, 0);
        cyc("t2_idle", 0, 0, 0, 0, 0, 0, 0);
        ops(0, 0, 0);
        cyc("t2z_done", 1, 0, 0, 0, 1, 0, 0);
        cyc("t2z_idle", 0, 0, 0, 0, 0, 0, 0);

        // abort during ON at sample_idx 2
        ops(0, 5, 0);
        cyc("t3_on0",   1, 0, 1, 1, 0, 0, 0);
        cyc("t3_on1",   0, 0, 1, 1, 0, 0, 1);
        cyc("t3_on2",   0, 0, 1, 1, 0, 0, 2);
        cyc("t3_abort", 0, 1, 0, 0, 0, 1, 0);
        cyc("t3_idle1", 0, 0, 0, 0, 0, 0, 0);
        cyc("t3_idle2", 0, 0, 0, 0, 0, 0, 0);

        // abort during PRE; abort in IDLE beats a coincident start
        ops(3, 1, 1);
        cyc("t3p_pre",   1, 0, 0, 1, 0, 0, 0);
        cyc("t3p_abort", 0, 1, 0, 0, 0, 1, 0);
        cyc("t3p_idle",  0, 0, 0, 0, 0, 0, 0);
        cyc("t3i_both",  1, 1, 0, 0, 0, 0, 0);
        cyc("t3i_abort", 0, 1, 0, 0, 0, 0, 0);

        // start while busy is dropped; start in the done cycle is taken with new operands
        ops(0, 2, 0);
        cyc("t4_on0",  1, 0, 1, 1, 0, 0, 0);
        ops(5, 5, 5);
        cyc("t4_on1",  1, 0, 1, 1, 0, 0, 1);
        cyc("t4_done", 0, 0, 0, 0, 1, 0, 0);
        ops(1, 1, 1);
        cyc("t4_pre",  1, 0, 0, 1, 0, 0, 0);
        cyc("t4_on",   0, 0, 1, 1, 0, 0, 0);
        cyc("t4_post", 0, 0, 0, 1, 0, 0, 0);
        cyc("t4_done2", 0, 0, 0, 0, 1, 0, 0);
        cyc("t4_idle", 0, 0, 0, 0, 0, 0, 0);

        // maximum 4-bit length: 15 ON cycles, index ends at 14
        ops(0, 15, 0);
        cyc("t6_on0", 1, 0, 1, 1, 0, 0, 0);
        for (int i = 1; i < 15; i++) cyc("t6_on", 0, 0, 1, 1, 0, 0, i);
        cyc("t6_done", 0, 0, 0, 0, 1, 0, 0);
        cyc("t6_idle", 0, 0, 0, 0, 0, 0, 0);

        // asynchronous reset in the middle of ON
        ops(0, 5, 0);
        cyc("t5_on0", 1, 0, 1, 1, 0, 0, 0);
        cyc("t5_on1", 0, 0, 1, 1, 0, 0, 1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("t5_async/w16", act16(), '0);
        check("t5_async/w4", act4(), '0);
        @(posedge clk);
        #1;
        check("t5_held/w16", act16(), '0);
        @(negedge clk);
        rst = 1'b0;
        ops(0, 1, 0);
        cyc("t5_restart", 1, 0, 1, 1, 0, 0, 0);
        cyc("t5_done",    0, 0, 0, 0, 1, 0, 0);
        cyc("t5_quiet1",  0, 0, 0, 0, 0, 0, 0);
        cyc("t5_quiet2",  0, 0, 0, 0, 0, 0, 0);

        waited = 0;
        while (sb.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expected entries left, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
